internal_node_sender: RTL and testbench

Transmit side of the internal-node load interface of the KD-tree. It pulls split words (dimension index plus median) from an upstream valid/ready source and streams them to the register-based internal node tree, one node per accepted beat, in breadth-first node order. The tree writes a node, and advances its write address, only on cycles where its load-window enable and sender_enable are both high. This block therefore holds data stable until that condition occurs and counts exactly NUM_NODES transfers.

---
 rtl/kd_tree_pkg.sv | 22 ++
 rtl/node_word_skid.sv | 33 +++
 rtl/internal_node_sender.sv | 90 +++++++++
 tb/tb_internal_node_sender.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/kd_tree_pkg.sv
// Shared constants, FSM encoding and word helpers for the KD-tree internal-node
// load path.
package kd_tree_pkg;

    localparam int INTERNAL_WIDTH = 22;
    localparam int MEDIAN_WIDTH   = 11;
    localparam int DIM_WIDTH      = INTERNAL_WIDTH - MEDIAN_WIDTH;
    localparam int NUM_DIMS       = 5;
    localparam int NUM_NODES      = 127;
    localparam int NODE_CNT_WIDTH = $clog2(NUM_NODES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } sender_state_t;

    function automatic logic [DIM_WIDTH-1:0] dim_field(input logic [INTERNAL_WIDTH-1:0] word);
        return word[INTERNAL_WIDTH-1:MEDIAN_WIDTH];
    endfunction

endpackage

// File: rtl/node_word_skid.sv
// One-entry output register toward the tree. It holds its word while the tree
// stalls and can reload in the same cycle it hands a word off.
module node_word_skid
    import kd_tree_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      flush,
    input  logic                      ready,
    input  logic [INTERNAL_WIDTH-1:0] word,
    output logic                      valid,
    output logic [INTERNAL_WIDTH-1:0] data,
    output logic                      has_room
);

    assign has_room = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= word;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/internal_node_sender.sv
// Streams NUM_NODES split words from an upstream valid/ready source into the
// register-based internal-node tree, in breadth-first order.
module internal_node_sender
    import kd_tree_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [INTERNAL_WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      tree_ready,
    output logic                      sender_enable,
    output logic [INTERNAL_WIDTH-1:0] sender_data,
    output logic [NODE_CNT_WIDTH-1:0] node_index,
    output logic                      busy,
    output logic                      done,
    output logic                      dim_error
);

    sender_state_t             state;
    logic [NODE_CNT_WIDTH-1:0] accepted;
    logic                      has_room;
    logic                      accept;
    logic                      transfer;
    logic                      flush;

    assign transfer = sender_enable && tree_ready;
    assign in_ready = (state == ST_SEND) && (accepted < NODE_CNT_WIDTH'(NUM_NODES)) && has_room;
    assign accept   = in_valid && in_ready;
    assign flush    = abort && (state != ST_IDLE);
    assign busy     = (state == ST_SEND);

    node_word_skid u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .flush    (flush),
        .ready    (tree_ready),
        .word     (in_data),
        .valid    (sender_enable),
        .data     (sender_data),
        .has_room (has_room)
    );

    // node_index and dim_error are left untouched on abort so software can read back where it stopped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            accepted   <= '0;
            node_index <= '0;
            done       <= 1'b0;
            dim_error  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_SEND;
                        accepted   <= '0;
                        node_index <= '0;
                        dim_error  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        if (accept) begin
                            accepted <= accepted + 1'b1;
                            if (dim_field(in_data) >= DIM_WIDTH'(NUM_DIMS))
                                dim_error <= 1'b1;
                        end
                        if (transfer) begin
                            node_index <= node_index + 1'b1;
                            if (node_index == NODE_CNT_WIDTH'(NUM_NODES - 1)) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_internal_node_sender.sv
// Randomized bench for internal_node_sender against a word-count scoreboard of
// accepted versus transferred nodes.
module tb_internal_node_sender;

    localparam int W     = 22;
    localparam int MW    = 11;
    localparam int NODES = 127;
    localparam int DIMS  = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic          tree_ready;
    logic          sender_enable;
    logic [W-1:0]  sender_data;
    logic [6:0]    node_index;
    logic          busy;
    logic          done;
    logic          dim_error;

    internal_node_sender dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .tree_ready    (tree_ready),
        .sender_enable (sender_enable),
        .sender_data   (sender_data),
        .node_index    (node_index),
        .busy          (busy),
        .done          (done),
        .dim_error     (dim_error)
    );

    always #5 clk = ~clk;

    // Reference: phase 0 idle, 1 loading, 2 done-pulse cycle; words in flight = acc_idx - xfr_idx
    int           vectors     = 0;
    int           miscompares = 0;
    int           phase       = 0;
    int           acc_idx     = 0;
    int           xfr_idx     = 0;
    bit           exp_dim_err = 1'b0;
    logic [W-1:0] words [NODES];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic fill_words(input bit rand_mode);
        for (int i = 0; i < NODES; i++) begin
            logic [MW-1:0] d;
            logic [MW-1:0] m;
            d = rand_mode ? MW'($urandom_range(0, DIMS - 1)) : '0;
            m = rand_mode ? MW'($urandom) : MW'(i);
            words[i] = {d, m};
        end
    endtask

    task automatic step(input bit vld, input bit trdy, input bit st, input bit ab);
        bit acc;
        bit xfer;
        int occ;
        logic [W-1:0] w;
        @(negedge clk);
        in_valid   = vld;
        tree_ready = trdy;
        start      = st;
        abort      = ab;
        in_data    = (acc_idx < NODES) ? words[acc_idx] : '0;
        #1;
        occ = acc_idx - xfr_idx;
        check("node_index", node_index, xfr_idx);
        check("dim_error", dim_error, exp_dim_err);
        check("done", done, phase == 2);
        check("busy", busy, phase == 1);
        if (phase == 1) begin
            check("sender_enable", sender_enable, occ != 0);
            if (occ != 0)
                check("sender_data", sender_data, words[xfr_idx]);
            check("in_ready", in_ready, (acc_idx < NODES) && (occ == 0 || trdy));
        end else begin
            check("idle_enable", sender_enable, 0);
            check("idle_ready", in_ready, 0);
        end
        acc  = vld && in_ready;
        xfer = sender_enable && trdy;
        @(posedge clk);
        case (phase)
            0: if (st) begin
                phase       = 1;
                acc_idx     = 0;
                xfr_idx     = 0;
                exp_dim_err = 1'b0;
            end
            1: if (ab) begin
                phase = 0;
            end else begin
                if (acc) begin
                    w = words[acc_idx];
                    if (int'(w[W-1:MW]) >= DIMS)
                        exp_dim_err = 1'b1;
                    acc_idx++;
                end
                if (xfer) begin
                    xfr_idx++;
                    if (xfr_idx == NODES)
                        phase = 2;
                end
            end
            default: phase = 0;
        endcase
    endtask

    task automatic run_until_idle(input int vld_pct, input int trdy_pct);
        int budget = 3000;
        while (phase != 0 && budget > 0) begin
            step($urandom_range(0, 99) < vld_pct, $urandom_range(0, 99) < trdy_pct, 1'b0, 1'b0);
            budget--;
        end
        check("load_timeout", phase, 0);
    endtask

    task automatic run_to_node(input int target);
        for (int k = 0; k < 400 && xfr_idx < target; k++)
            step(1'b1, 1'b1, 1'b0, 1'b0);
        check("reach_node", xfr_idx, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        in_valid   = 1'b0;
        tree_ready = 1'b0;
        in_data    = '0;
        fill_words(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_enable", sender_enable, 0);
        check("rst_data", sender_data, 0);
        check("rst_ready", in_ready, 0);
        check("rst_index", node_index, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dim", dim_error, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-throughput load of words 0..126
        step(1'b0, 1'b1, 1'b1, 1'b0);
        run_until_idle(100, 100);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);

        // Stall on word 0x0A5
        fill_words(1'b1);
        words[5] = 22'h0A5;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        run_to_node(5);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        run_until_idle(100, 100);

        // Bubbles both sides, illegal dim at node 3
        fill_words(1'b1);
        words[3] = {11'd7, 11'($urandom)};
        step(1'b0, 1'b1, 1'b1, 1'b0);
        run_until_idle(50, 70);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Abort with a stalled word at node 40, then a clean reload
        fill_words(1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        run_to_node(40);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        run_until_idle(60, 60);

        // Start while busy is ignored; async reset mid-load
        fill_words(1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        run_to_node(10);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        run_to_node(20);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_enable", sender_enable, 0);
        check("arst_data", sender_data, 0);
        check("arst_ready", in_ready, 0);
        check("arst_index", node_index, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_dim", dim_error, 0);
        phase       = 0;
        acc_idx     = 0;
        xfr_idx     = 0;
        exp_dim_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        run_until_idle(80, 80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
